// File: rtl/serdes_pkg.sv
// Shared serdes types: the two-state frame controller encoding used by both
// the serializer and the deserializer control blocks.
package serdes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1
    } serdes_state_e;

endpackage

// File: rtl/serializer_if.sv
// Frame-in / word-out handshake bundle for the serializer.
// Optional macro SERIALIZER_LAST_EN adds the send_last frame delimiter.
interface serializer_if #(
    parameter int unsigned N_SAMPLES = 8,
    parameter int unsigned BIT_WIDTH = 32
);
    logic                 recv_val;
    logic                 recv_rdy;
    logic [BIT_WIDTH-1:0] recv_msg [N_SAMPLES];
    logic                 send_val;
    logic                 send_rdy;
    logic [BIT_WIDTH-1:0] send_msg;
`ifdef SERIALIZER_LAST_EN
    logic                 send_last;
`endif

    // Serializer side
    modport slave (
        input  recv_val, recv_msg, send_rdy,
        output recv_rdy, send_val, send_msg
`ifdef SERIALIZER_LAST_EN
        , output send_last
`endif
    );

    // Producer / consumer side
    modport master (
        output recv_val, recv_msg, send_rdy,
        input  recv_rdy, send_val, send_msg
`ifdef SERIALIZER_LAST_EN
        , input send_last
`endif
    );
endinterface

// File: rtl/cmn_EnResetReg.sv
// Common enabled register with synchronous active-high reset to zero.
module cmn_EnResetReg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // Load d when enabled, otherwise hold
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (en)
            q <= d;
    end
endmodule

// File: rtl/serializer_ctrl.sv
// Serializer control: IDLE/SEND FSM plus word index counter.
// All outputs registered; load_en is the recv handshake (recv_rdy is a flop).
// Optional macro SERIALIZER_LAST_EN adds the registered send_last output.
module serializer_ctrl
    import serdes_pkg::*;
#(
    parameter int unsigned N_SAMPLES = 8,
    parameter int unsigned IDX_W     = $clog2(N_SAMPLES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             recv_val,
    input  logic             send_rdy,
    output logic             load_en,
    output logic [IDX_W-1:0] idx,
    output logic             send_val,
    output logic             recv_rdy
`ifdef SERIALIZER_LAST_EN
    , output logic           send_last
`endif
);
    localparam logic [IDX_W:0] IDX_END  = (IDX_W+1)'(N_SAMPLES);
    localparam logic [IDX_W:0] IDX_LAST = (IDX_W+1)'(N_SAMPLES - 1);

    serdes_state_e  state;
    logic [IDX_W:0] idx_next;

    assign idx_next = {1'b0, idx} + 1'b1;
    assign load_en  = recv_val && recv_rdy;

    // Frame FSM with registered handshake outputs and index counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            recv_rdy <= 1'b1;
            send_val <= 1'b0;
`ifdef SERIALIZER_LAST_EN
            send_last <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (recv_val) begin
                        state    <= SEND;
                        idx      <= '0;
                        recv_rdy <= 1'b0;
                        send_val <= 1'b1;
                    end
                end
                SEND: begin
                    if (send_rdy) begin
                        if (idx_next == IDX_END) begin
                            state    <= IDLE;
                            idx      <= '0;
                            recv_rdy <= 1'b1;
                            send_val <= 1'b0;
`ifdef SERIALIZER_LAST_EN
                            send_last <= 1'b0;
`endif
                        end else begin
                            idx <= idx_next[IDX_W-1:0];
`ifdef SERIALIZER_LAST_EN
                            send_last <= (idx_next == IDX_LAST);
`endif
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    idx      <= '0;
                    recv_rdy <= 1'b1;
                    send_val <= 1'b0;
`ifdef SERIALIZER_LAST_EN
                    send_last <= 1'b0;
`endif
                end
            endcase
        end
    end
endmodule

// File: rtl/serializer.sv
// Parallel-to-serial stage: registers a whole frame on one recv handshake,
// then emits words index 0 first, one per send handshake.
// Optional macro SERIALIZER_LAST_EN drives send_last on the final word.
module serializer
    import serdes_pkg::*;
#(
    parameter int unsigned N_SAMPLES = 8,
    parameter int unsigned BIT_WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    serializer_if.slave     io
);
    localparam int unsigned IDX_W = $clog2(N_SAMPLES);

    logic                 load_en;
    logic [IDX_W-1:0]     idx;
    logic                 send_val;
    logic                 recv_rdy;
    logic [BIT_WIDTH-1:0] data_q [N_SAMPLES];
`ifdef SERIALIZER_LAST_EN
    logic                 send_last;
`endif

    serializer_ctrl #(
        .N_SAMPLES (N_SAMPLES),
        .IDX_W     (IDX_W)
    ) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .recv_val  (io.recv_val),
        .send_rdy  (io.send_rdy),
        .load_en   (load_en),
        .idx       (idx),
        .send_val  (send_val),
        .recv_rdy  (recv_rdy)
`ifdef SERIALIZER_LAST_EN
        , .send_last (send_last)
`endif
    );

    for (genvar i = 0; i < N_SAMPLES; i++) begin : g_data
        cmn_EnResetReg #(
            .WIDTH (BIT_WIDTH)
        ) u_reg (
            .clk   (clk),
            .reset (reset),
            .en    (load_en),
            .d     (io.recv_msg[i]),
            .q     (data_q[i])
        );
    end

    assign io.recv_rdy = recv_rdy;
    assign io.send_val = send_val;
    assign io.send_msg = data_q[idx];
`ifdef SERIALIZER_LAST_EN
    assign io.send_last = send_last;
`endif
endmodule
